game_control_fsm: RTL

Top-level game sequencer for the obstacle dodger, replacing the single-run four-state controller. It adds multiple lives, multiple levels, pause, a timed respawn/erase phase, and terminal win/lose states. It drives the plotter enables (`writeEnable`, `draw`, `erase`) and the object-motion enable (`setoff`). It takes collision and end-of-track flags from the datapath and the start and pause keys from the board.

---
 rtl/game_control_fsm.sv | 117 +++++++++++
 1 files changed

// File: rtl/game_control_fsm.sv
// Game sequencer for the obstacle dodger: start/load, play, pause, timed respawn,
// level advance and terminal win/lose, with registered Moore outputs to the plotter.
module game_control_fsm #(
  parameter int NUM_LIVES      = 3,
  parameter int NUM_LEVELS     = 4,
  parameter int RESPAWN_CYCLES = 16,
  parameter int LIVE_W         = 2,
  parameter int LEVEL_W        = 2
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               ld,
  input  logic               pause,
  input  logic               hit,
  input  logic               reached_end,
  output logic               writeEnable,
  output logic               draw,
  output logic               erase,
  output logic               setoff,
  output logic [LIVE_W-1:0]  lives,
  output logic [LEVEL_W-1:0] level,
  output logic               game_over,
  output logic               game_won,
  output logic [2:0]         fsm_state
);

  localparam int CNT_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_BEGIN    = 3'd0,
    S_LOAD     = 3'd1,
    S_PLOT     = 3'd2,
    S_PAUSE    = 3'd3,
    S_RESPAWN  = 3'd4,
    S_LEVEL_UP = 3'd5,
    S_WIN      = 3'd6,
    S_LOSE     = 3'd7
  } state_t;

  state_t             state, state_nxt;
  logic [LIVE_W-1:0]  lives_nxt;
  logic [LEVEL_W-1:0] level_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  assign fsm_state = state;

  always_comb begin
    state_nxt = state;
    lives_nxt = lives;
    level_nxt = level;
    cnt_nxt   = cnt;
    case (state)
      S_BEGIN: if (ld) state_nxt = S_LOAD;
      S_LOAD:  if (!ld) state_nxt = S_PLOT;
      S_PLOT: begin
        // hit outranks reached_end, which outranks pause
        if (hit) begin
          if (lives <= LIVE_W'(1)) begin
            state_nxt = S_LOSE;
            lives_nxt = '0;
          end else begin
            state_nxt = S_RESPAWN;
            lives_nxt = lives - LIVE_W'(1);
            cnt_nxt   = CNT_W'(RESPAWN_CYCLES - 1);
          end
        end else if (reached_end) begin
          if (level == LEVEL_W'(NUM_LEVELS - 1)) begin
            state_nxt = S_WIN;
          end else begin
            state_nxt = S_LEVEL_UP;
            level_nxt = level + LEVEL_W'(1);
          end
        end else if (pause) begin
          state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: if (!pause) state_nxt = S_PLOT;
      S_RESPAWN: begin
        if (cnt == '0) state_nxt = S_PLOT;
        else cnt_nxt = cnt - CNT_W'(1);
      end
      S_LEVEL_UP: state_nxt = S_BEGIN;
      S_WIN:      state_nxt = S_WIN;
      S_LOSE:     state_nxt = S_LOSE;
      default:    state_nxt = S_BEGIN;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= S_BEGIN;
      lives       <= LIVE_W'(NUM_LIVES);
      level       <= '0;
      cnt         <= '0;
      writeEnable <= 1'b1;
      draw        <= 1'b1;
      erase       <= 1'b0;
      setoff      <= 1'b0;
      game_over   <= 1'b0;
      game_won    <= 1'b0;
    end else begin
      state       <= state_nxt;
      lives       <= lives_nxt;
      level       <= level_nxt;
      cnt         <= cnt_nxt;
      writeEnable <= (state_nxt == S_BEGIN) || (state_nxt == S_PLOT) ||
                     (state_nxt == S_RESPAWN) || (state_nxt == S_LEVEL_UP);
      draw        <= (state_nxt == S_BEGIN) || (state_nxt == S_PLOT);
      erase       <= (state_nxt == S_RESPAWN) || (state_nxt == S_LEVEL_UP);
      setoff      <= (state_nxt == S_PLOT);
      game_over   <= (state_nxt == S_LOSE);
      game_won    <= (state_nxt == S_WIN);
    end
  end

endmodule
